// File: rtl/dft_hijack_ctrl.sv
// Control sequencer for a DFT driver-hijack cell: unlock/enable ordering,
// forced-value updates, and synchronized readback checking.
module dft_hijack_ctrl #(
    parameter int UNLOCK_CYC = 4,
    parameter int SETTLE_CYC = 6,
    parameter int HOLD_CYC   = 3,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic       cmd_value,
    output logic       unlock,
    output logic       ten_hijack,
    output logic       ten_hijacki,
    input  logic       hijack_o,
    output logic       rsp_valid,
    output logic       rsp_pass,
    output logic       rsp_err,
    output logic       rsp_obs,
    output logic       busy
);

    localparam logic [1:0] OP_ENGAGE  = 2'b01;
    localparam logic [1:0] OP_SET     = 2'b10;
    localparam logic [1:0] OP_RELEASE = 2'b11;

    localparam logic [CNT_W-1:0] UNLK_LOAD   = CNT_W'(UNLOCK_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYC - 1);

    typedef enum logic [2:0] {
        S_OFF, S_UNLK, S_SETTLE, S_CHECK, S_ON, S_REL, S_ERR
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             err_on, err_on_nxt;
    logic             ten_hijacki_nxt;
    logic             unlock_nxt, ten_hijack_nxt, cmd_ready_nxt, busy_nxt;
    logic             hijack_o_p0, obs_s;
    logic             cmd_fire;

    assign cmd_fire = cmd_valid && cmd_ready;

    // hijack_o is asynchronous to clk; only obs_s is used downstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hijack_o_p0 <= 1'b0;
            obs_s       <= 1'b0;
        end else begin
            hijack_o_p0 <= hijack_o;
            obs_s       <= hijack_o_p0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_OFF;
            cnt         <= '0;
            err_on      <= 1'b0;
            ten_hijacki <= 1'b0;
            unlock      <= 1'b0;
            ten_hijack  <= 1'b0;
            cmd_ready   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            err_on      <= err_on_nxt;
            ten_hijacki <= ten_hijacki_nxt;
            unlock      <= unlock_nxt;
            ten_hijack  <= ten_hijack_nxt;
            cmd_ready   <= cmd_ready_nxt;
            busy        <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
        err_on_nxt      = err_on;
        ten_hijacki_nxt = ten_hijacki;
        case (state)
            S_OFF: begin
                if (cmd_fire) begin
                    if (cmd_op == OP_ENGAGE) begin
                        state_nxt       = S_UNLK;
                        cnt_nxt         = UNLK_LOAD;
                        ten_hijacki_nxt = cmd_value;
                    end else if (cmd_op == OP_SET || cmd_op == OP_RELEASE) begin
                        state_nxt  = S_ERR;
                        err_on_nxt = 1'b0;
                    end
                end
            end
            S_UNLK: begin
                if (cnt == '0) begin
                    state_nxt = S_SETTLE;
                    cnt_nxt   = SETTLE_LOAD;
                end
            end
            S_SETTLE: begin
                if (cnt == '0) state_nxt = S_CHECK;
            end
            S_CHECK: state_nxt = S_ON;
            S_ON: begin
                if (cmd_fire) begin
                    if (cmd_op == OP_SET) begin
                        state_nxt       = S_SETTLE;
                        cnt_nxt         = SETTLE_LOAD;
                        ten_hijacki_nxt = cmd_value;
                    end else if (cmd_op == OP_RELEASE) begin
                        state_nxt = S_REL;
                        cnt_nxt   = HOLD_LOAD;
                    end else if (cmd_op == OP_ENGAGE) begin
                        state_nxt  = S_ERR;
                        err_on_nxt = 1'b1;
                    end
                end
            end
            S_REL: begin
                if (cnt == '0) begin
                    state_nxt       = S_OFF;
                    ten_hijacki_nxt = 1'b0;
                end
            end
            S_ERR:   state_nxt = err_on ? S_ON : S_OFF;
            default: state_nxt = S_OFF;
        endcase
    end

    // Cell-facing outputs are registered from the next state so they never glitch
    always_comb begin
        unlock_nxt     = 1'b0;
        ten_hijack_nxt = 1'b0;
        cmd_ready_nxt  = (state_nxt == S_OFF) || (state_nxt == S_ON);
        busy_nxt       = !cmd_ready_nxt;
        case (state_nxt)
            S_UNLK, S_REL: unlock_nxt = 1'b1;
            S_SETTLE, S_CHECK, S_ON: begin
                unlock_nxt     = 1'b1;
                ten_hijack_nxt = 1'b1;
            end
            S_ERR: begin
                unlock_nxt     = err_on_nxt;
                ten_hijack_nxt = err_on_nxt;
            end
            default: ;
        endcase

        rsp_valid = 1'b0;
        rsp_pass  = 1'b0;
        rsp_err   = 1'b0;
        rsp_obs   = 1'b0;
        case (state)
            S_CHECK: begin
                rsp_valid = 1'b1;
                rsp_obs   = obs_s;
                rsp_pass  = (obs_s == ten_hijacki);
            end
            S_REL: begin
                if (cnt == '0) begin
                    rsp_valid = 1'b1;
                    rsp_pass  = 1'b1;
                    rsp_obs   = obs_s;
                end
            end
            S_ERR: begin
                rsp_valid = 1'b1;
                rsp_err   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dft_hijack_ctrl.sv
// Directed bench for dft_hijack_ctrl: cycle-exact sequencing, readback, errors, reset.
module tb_dft_hijack_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic       cmd_value = 1'b0;
    logic       unlock, ten_hijack, ten_hijacki;
    logic       hijack_o;
    logic       rsp_valid, rsp_pass, rsp_err, rsp_obs, busy;

    logic tie = 1'b1;
    logic stuck = 1'b0;
    int   n_run = 0;
    int   n_fail = 0;

    localparam logic [1:0] ENGAGE = 2'b01, SET = 2'b10, RELEASE = 2'b11;

    always #5 clk = ~clk;
    assign hijack_o = tie ? ten_hijacki : stuck;

    dft_hijack_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_value(cmd_value), .unlock(unlock), .ten_hijack(ten_hijack),
        .ten_hijacki(ten_hijacki), .hijack_o(hijack_o), .rsp_valid(rsp_valid),
        .rsp_pass(rsp_pass), .rsp_err(rsp_err), .rsp_obs(rsp_obs), .busy(busy)
    );

    // Continuous invariants: enable needs unlock; response fields idle when no response
    always @(negedge clk) begin
        if (rst_n) begin
            n_run++;
            if (ten_hijack === 1'b1 && unlock !== 1'b1) begin
                n_fail++;
                $display("FAIL inv_unlock: ten_hijack=%b unlock=%b", ten_hijack, unlock);
            end
            n_run++;
            if (rsp_valid === 1'b0 && {rsp_pass, rsp_err, rsp_obs} !== 3'b000) begin
                n_fail++;
                $display("FAIL inv_rsp_idle: pass/err/obs=%b want 000", {rsp_pass, rsp_err, rsp_obs});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [8:0] got;
        repeat (2) @(posedge clk);
        #1;
        got = {cmd_ready, unlock, ten_hijack, ten_hijacki, rsp_valid, rsp_pass, rsp_err, rsp_obs, busy};
        n_run++;
        if (got !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want %b", got, 9'b0);
        end
        rst_n = 1'b1;
        tick();
        got = {cmd_ready, unlock, ten_hijack, ten_hijacki, rsp_valid, rsp_pass, rsp_err, rsp_obs, busy};
        n_run++;
        if (got !== 9'b1_0000_0000) begin
            n_fail++;
            $display("FAIL reset_idle: got %b want %b", got, 9'b1_0000_0000);
        end
    endtask

    task automatic test_engage();
        logic [4:0] got, exp;
        tie = 1'b1;
        cmd_op = ENGAGE; cmd_value = 1'b1; cmd_valid = 1'b1;
        n_run++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL engage_ready: got %b want 1", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            got = {unlock, ten_hijack, ten_hijacki, rsp_valid, cmd_ready};
            exp = {1'b1, k >= 5, 1'b1, k == 11, k == 12};
            n_run++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL engage T+%0d: unl/th/thi/rv/rdy got %b want %b", k, got, exp);
            end
            if (k == 11) begin
                n_run++;
                if ({rsp_pass, rsp_obs, rsp_err} !== 3'b110) begin
                    n_fail++;
                    $display("FAIL engage_rsp: pass/obs/err got %b want 110", {rsp_pass, rsp_obs, rsp_err});
                end
            end
            if (k < 12) tick();
        end
    endtask

    task automatic test_set(input logic use_tie, input logic stuck_v, input logic val,
                            input logic [2:0] exp_rsp);
        logic [4:0] got, exp;
        tie = use_tie; stuck = stuck_v;
        cmd_op = SET; cmd_value = val; cmd_valid = 1'b1;
        n_run++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL set_ready: got %b want 1", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            got = {unlock, ten_hijack, ten_hijacki, rsp_valid, cmd_ready};
            exp = {1'b1, 1'b1, val, k == 7, k == 8};
            n_run++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL set T+%0d: unl/th/thi/rv/rdy got %b want %b", k, got, exp);
            end
            if (k == 7) begin
                n_run++;
                if ({rsp_pass, rsp_obs, rsp_err} !== exp_rsp) begin
                    n_fail++;
                    $display("FAIL set_rsp: pass/obs/err got %b want %b", {rsp_pass, rsp_obs, rsp_err}, exp_rsp);
                end
            end
            if (k < 8) tick();
        end
    endtask

    task automatic test_illegal(input logic [1:0] op, input logic [2:0] hold);
        logic [4:0] got, exp;
        cmd_op = op; cmd_value = 1'b1; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        got = {unlock, ten_hijack, ten_hijacki, rsp_valid, cmd_ready};
        exp = {hold, 1'b1, 1'b0};
        n_run++;
        if (got !== exp || rsp_err !== 1'b1 || rsp_pass !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal op=%b: unl/th/thi/rv/rdy got %b want %b err=%b pass=%b",
                     op, got, exp, rsp_err, rsp_pass);
        end
        tick();
        got = {unlock, ten_hijack, ten_hijacki, rsp_valid, cmd_ready};
        exp = {hold, 1'b0, 1'b1};
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL illegal_return op=%b: got %b want %b", op, got, exp);
        end
    endtask

    task automatic test_release(input logic thi);
        logic [4:0] got, exp;
        tie = 1'b1;
        cmd_op = RELEASE; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            got = {unlock, ten_hijack, ten_hijacki, rsp_valid, cmd_ready};
            exp = {k <= 3, 1'b0, (k <= 3) ? thi : 1'b0, k == 3, k == 4};
            n_run++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL release T+%0d: unl/th/thi/rv/rdy got %b want %b", k, got, exp);
            end
            if (k == 3) begin
                n_run++;
                if ({rsp_pass, rsp_obs, rsp_err} !== {1'b1, thi, 1'b0}) begin
                    n_fail++;
                    $display("FAIL release_rsp: pass/obs/err got %b want %b",
                             {rsp_pass, rsp_obs, rsp_err}, {1'b1, thi, 1'b0});
                end
            end
            if (k < 4) tick();
        end
    endtask

    task automatic test_back_to_back();
        tie = 1'b1;
        cmd_op = ENGAGE; cmd_value = 1'b1; cmd_valid = 1'b1;
        tick();
        for (int k = 1; k <= 12; k++) begin
            n_run++;
            if ({cmd_ready, rsp_valid, rsp_err} !== {k == 12, k == 11, 1'b0}) begin
                n_fail++;
                $display("FAIL holdoff T+%0d: rdy/rv/err got %b want %b", k,
                         {cmd_ready, rsp_valid, rsp_err}, {k == 12, k == 11, 1'b0});
            end
            tick();
        end
        cmd_valid = 1'b0;
        n_run++;
        if ({rsp_valid, rsp_err, cmd_ready} !== 3'b110) begin
            n_fail++;
            $display("FAIL holdoff_second: rv/err/rdy got %b want 110", {rsp_valid, rsp_err, cmd_ready});
        end
        tick();
        n_run++;
        if ({cmd_ready, unlock, ten_hijack, ten_hijacki} !== 4'b1111) begin
            n_fail++;
            $display("FAIL holdoff_on: rdy/unl/th/thi got %b want 1111",
                     {cmd_ready, unlock, ten_hijack, ten_hijacki});
        end
    endtask

    task automatic test_reset_mid();
        tie = 1'b1;
        cmd_op = ENGAGE; cmd_value = 1'b1; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        repeat (6) tick();
        n_run++;
        if ({unlock, ten_hijack, busy} !== 3'b111) begin
            n_fail++;
            $display("FAIL rstmid_pre: unl/th/busy got %b want 111", {unlock, ten_hijack, busy});
        end
        #2 rst_n = 1'b0;
        #1;
        n_run++;
        if ({unlock, ten_hijack, ten_hijacki, rsp_valid, cmd_ready, busy} !== 6'b0) begin
            n_fail++;
            $display("FAIL rstmid_async: unl/th/thi/rv/rdy/busy got %b want 000000",
                     {unlock, ten_hijack, ten_hijacki, rsp_valid, cmd_ready, busy});
        end
        repeat (2) tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            n_run++;
            if ({rsp_valid, unlock, ten_hijack, cmd_ready, busy} !== 5'b00010) begin
                n_fail++;
                $display("FAIL rstmid_after +%0d: rv/unl/th/rdy/busy got %b want 00010", k,
                         {rsp_valid, unlock, ten_hijack, cmd_ready, busy});
            end
        end
    endtask

    initial begin
        test_reset();
        test_engage();
        test_set(1'b0, 1'b1, 1'b0, 3'b010);
        test_set(1'b1, 1'b0, 1'b0, 3'b100);
        test_illegal(ENGAGE, 3'b110);
        test_release(1'b0);
        test_illegal(SET, 3'b000);
        test_back_to_back();
        test_release(1'b1);
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

endmodule

// File: doc/dft_hijack_ctrl.md
Name: dft_hijack_ctrl

Overview:
- Sequencer that drives the control side of a DFT driver-hijack cell: `unlock`, `ten_hijack` (enable) and `ten_hijacki` (forced value).
- Reads back the cell's hijacked output `o` and checks it.
- Enforces the cell's ordering rules: unlock before enable, enable dropped before unlock on release.
- Sits between the test-access command decoder and one hijack cell instance.

Parameters:
- UNLOCK_CYC, 4: cycles `unlock` is high before `ten_hijack` rises (≥1).
- SETTLE_CYC, 6: cycles after an enable/value change before readback is compared (≥3; covers 2-flop sync).
- HOLD_CYC, 3: cycles `unlock` stays high after `ten_hijack` falls on release (≥1).
- CNT_W, 4: counter width; must hold max(UNLOCK_CYC, SETTLE_CYC, HOLD_CYC).

Ports:
- clk, input, 1: block clock.
- rst_n, input, 1: asynchronous active-low reset.
- cmd_valid, input, 1: command present.
- cmd_ready, output, 1: command accepted on the edge where cmd_valid && cmd_ready.
- cmd_op, input, 2: 00 NOP, 01 ENGAGE, 10 SET, 11 RELEASE.
- cmd_value, input, 1: forced value for ENGAGE/SET.
- unlock, output, 1: to cell unlock.
- ten_hijack, output, 1: to cell hijack enable.
- ten_hijacki, output, 1: to cell forced value.
- hijack_o, input, 1: cell output; asynchronous to clk.
- rsp_valid, output, 1: one-cycle response pulse.
- rsp_pass, output, 1: readback matched, or command needed no check.
- rsp_err, output, 1: illegal command for the current state.
- rsp_obs, output, 1: synchronized readback value at response.
- busy, output, 1: high in every state except OFF and ON.

Behaviour:
- Reset (asynchronous, immediate): every output is 0; state OFF; counter 0; sync flops 0.
- hijack_o passes through a 2-flop synchronizer (`obs_s`) before any use.
- States: OFF, UNLK, SETTLE, CHECK, ON, REL, ERR.
- cmd_ready = 1 only in OFF and ON.
- OFF: unlock=0, ten_hijack=0, ten_hijacki=0.
  - ENGAGE accepted at edge T: UNLK from T+1; unlock=1; ten_hijacki=cmd_value.
  - NOP: no response.
  - SET or RELEASE: ERR.
- UNLK: lasts exactly UNLOCK_CYC cycles, then SETTLE with ten_hijack=1.
  - ten_hijack first high at T+1+UNLOCK_CYC.
- SETTLE: lasts exactly SETTLE_CYC cycles; outputs held; then CHECK.
- CHECK: single cycle; rsp_valid=1, rsp_obs=obs_s, rsp_pass=(obs_s==ten_hijacki), rsp_err=0; then ON.
  - Default ENGAGE: rsp_valid at T+11.
- ON: unlock=1, ten_hijack=1.
  - SET accepted: ten_hijacki=cmd_value next cycle; SETTLE then CHECK. Same latency as ENGAGE minus UNLOCK_CYC: rsp at T+1+SETTLE_CYC.
  - SET with unchanged value is still rechecked.
  - RELEASE accepted at T: REL from T+1 with ten_hijack=0, unlock=1.
  - ENGAGE: ERR.
- REL: lasts exactly HOLD_CYC cycles.
  - Last REL cycle: rsp_valid=1, rsp_pass=1, rsp_obs=obs_s.
  - Next cycle: OFF with unlock=0, ten_hijacki=0.
  - ten_hijack and unlock never fall on the same edge except under reset.
- ERR: single cycle; rsp_valid=1, rsp_err=1, rsp_pass=0; returns to the originating state (OFF or ON). Hijack outputs unchanged.
- rsp_* fields other than rsp_valid are 0 whenever rsp_valid=0.
- Invariants:
  - ten_hijack=1 implies unlock=1.
  - ten_hijacki changes only in OFF→UNLK, on SET acceptance, and on REL→OFF.
- Commands presented while busy are held off (cmd_ready=0), never dropped or queued internally.
- rst_n low mid-sequence: all outputs 0 at once; a pending response is lost; no response after reset release.
- Counter loads N-1 on state entry and decrements to 0. No wrap: the count is fixed per state.

Test Plan:
- Reset, then ENGAGE value=1 at T with hijack_o tied to ten_hijacki → unlock↑ at T+1, ten_hijack↑ at T+5, rsp_valid at T+11 with pass=1, obs=1; cmd_ready=1 from T+12.
- In ON, SET value=0 with hijack_o stuck at 1 → ten_hijacki=0 at T+1, rsp_valid at T+7 with pass=0, obs=1; state stays ON (ten_hijack=1).
- In ON, RELEASE at T → ten_hijack=0 at T+1 while unlock=1 for T+1..T+3; rsp pass=1 at T+3; unlock=0 at T+4; never ten_hijack=1 with unlock=0.
- SET in OFF, and ENGAGE in ON → one-cycle rsp_err=1, no change on unlock/ten_hijack/ten_hijacki.
- cmd_valid held high with ENGAGE during UNLK/SETTLE → cmd_ready=0 throughout; no second accept until ON.
- rst_n low during SETTLE → unlock, ten_hijack, ten_hijacki, rsp_valid all 0 immediately; after rst_n rises, no response and state OFF.
